// File: rtl/hack_vga_scanout_if.sv
// Port B link between hack_vga_scanout and the Hack screen buffer (0x4000-0x5FFF).
// The scan-out side is the master; it only ever reads.
interface hack_vga_scanout_if;
  logic        rd_en;
  logic [12:0] rd_addr;
  logic [15:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/hack_vga_scanout.sv
// 640x480@60 VGA scan-out of the 512x256 1-bpp Hack screen, centred, one word fetched per 16 pixels.
// Define HACK_VGA_BORDER_EN to paint the visible border blue instead of black.
module hack_vga_scanout #(
  parameter int CLK_DIV  = 2,
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SCR_X0   = 64,
  parameter int SCR_Y0   = 112,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  hack_vga_scanout_if.master        mem,
  output logic                      hsync,
  output logic                      vsync,
  output logic [2:0]                rgb,
  output logic                      frame_start
);

  localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST     = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]       V_LAST     = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]       H_VIS_C    = 10'(H_VIS);
  localparam logic [9:0]       V_VIS_C    = 10'(V_VIS);
  localparam logic [9:0]       HS_BEG     = 10'(H_VIS + H_FP);
  localparam logic [9:0]       HS_END     = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0]       VS_BEG     = 10'(V_VIS + V_FP);
  localparam logic [9:0]       VS_END     = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0]       X0         = 10'(SCR_X0);
  localparam logic [9:0]       Y0         = 10'(SCR_Y0);
  // Fetches run two ticks ahead of the pixels they feed.
  localparam logic [9:0]       FETCH_X0   = 10'(SCR_X0 - 2);
  localparam logic [9:0]       FETCH_SPAN = 10'd496;
  localparam logic [2:0]       INK        = 3'b000;
  localparam logic [2:0]       PAPER      = 3'b111;
`ifdef HACK_VGA_BORDER_EN
  localparam logic [2:0]       BORDER_RGB = 3'b001;
`else
  localparam logic [2:0]       BORDER_RGB = 3'b000;
`endif

  logic [DIV_W-1:0] div;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [15:0]      shreg;

  logic             tick;
  logic             h_wrap;
  logic             v_wrap;
  logic [9:0]       wx;
  logic [9:0]       wy;
  logic [9:0]       fx;
  logic             in_x;
  logic             in_y;
  logic             visible;
  logic             fetch_hit;
  logic             hs_on;
  logic             vs_on;
  logic [15:0]      pix_word;
  logic [2:0]       rgb_next;

  // NOTE: every always_comb output gets a value first so no latch can be inferred.
  always_comb begin
    tick      = (div == DIV_LAST);
    h_wrap    = (h_cnt == H_LAST);
    v_wrap    = (v_cnt == V_LAST);
    // Out-of-range positions wrap to large unsigned values and fail the range tests.
    wx        = h_cnt - X0;
    wy        = v_cnt - Y0;
    fx        = h_cnt - FETCH_X0;
    in_x      = (wx < 10'd512);
    in_y      = (wy < 10'd256);
    visible   = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    fetch_hit = in_y && (fx <= FETCH_SPAN) && (fx[3:0] == 4'd0);
    hs_on     = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
    vs_on     = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
    // On a word boundary the fresh read data supplies the leftmost pixel directly.
    pix_word  = (in_x && (wx[3:0] == 4'd0)) ? mem.rd_data : shreg;
    rgb_next  = 3'b000;
    if (visible) begin
      if (in_x && in_y) rgb_next = pix_word[0] ? INK : PAPER;
      else              rgb_next = BORDER_RGB;
    end
  end

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div         <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      shreg       <= '0;
      mem.rd_en   <= 1'b0;
      mem.rd_addr <= '0;
      rgb         <= 3'b000;
      frame_start <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
    end else begin
      mem.rd_en   <= 1'b0;
      frame_start <= 1'b0;
      if (tick) begin
        div         <= '0;
        h_cnt       <= h_wrap ? '0 : h_cnt + 10'd1;
        if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
        hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
        vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
        rgb         <= rgb_next;
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
        if (fetch_hit) begin
          mem.rd_en   <= 1'b1;
          mem.rd_addr <= {wy[7:0], fx[8:4]};
        end
        if (in_x && in_y) shreg <= {1'b0, pix_word[15:1]};
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hack_vga_scanout.sv
// Bench for hack_vga_scanout: full-width lines with a shortened vertical frame,
// random screen contents and an arithmetic reference model of every tick.
module tb_hack_vga_scanout;

  localparam int CLK_DIV  = 2;
  localparam int H_VIS    = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_VIS    = 8;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int SCR_X0   = 64;
  localparam int SCR_Y0   = 3;
  localparam bit SYNC_POL = 1'b0;
`ifdef HACK_VGA_BORDER_EN
  localparam logic [2:0] BORDER = 3'b001;
`else
  localparam logic [2:0] BORDER = 3'b000;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       hsync;
  logic       vsync;
  logic [2:0] rgb;
  logic       frame_start;

  hack_vga_scanout_if bus ();

  hack_vga_scanout #(
    .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SCR_X0(SCR_X0), .SCR_Y0(SCR_Y0), .SYNC_POL(SYNC_POL)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .mem(bus),
    .hsync(hsync),
    .vsync(vsync),
    .rgb(rgb),
    .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  // Screen buffer port B: registered read, output holds between reads.
  logic [15:0] mem_img [8192];
  always @(posedge clock) if (bus.rd_en) bus.rd_data <= mem_img[bus.rd_addr];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          tick_n;
  int          strobes;
  int          exp_strobes;
  logic [12:0] last_addr;
  logic        e_hs, e_vs, e_fs, e_re;
  logic [2:0]  e_rgb;
  logic        p_hs, p_vs;
  logic [2:0]  p_rgb;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (tick %0d)", tag, obs, exp, tick_n);
    end
  endtask

  // Expected registered outputs for the n-th tick after reset release.
  task automatic predict(input int n);
    int h, v, x, y, fx;
    logic [15:0] w;
    h  = n % H_TOT;
    v  = (n / H_TOT) % V_TOT;
    x  = h - SCR_X0;
    y  = v - SCR_Y0;
    fx = h - (SCR_X0 - 2);
    e_hs = (h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC) ? SYNC_POL : !SYNC_POL;
    e_vs = (v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC) ? SYNC_POL : !SYNC_POL;
    e_fs = (h == 0 && v == 0);
    e_rgb = 3'b000;
    if (h < H_VIS && v < V_VIS) begin
      if (x >= 0 && x < 512 && y >= 0 && y < 256) begin
        w = mem_img[y * 32 + x / 16];
        e_rgb = w[x % 16] ? 3'b000 : 3'b111;
      end else begin
        e_rgb = BORDER;
      end
    end
    e_re = (y >= 0 && y < 256 && fx >= 0 && fx < 512 && fx % 16 == 0);
    if (e_re) begin
      last_addr = 13'(y * 32 + fx / 16);
      exp_strobes++;
    end
  endtask

  task automatic restart_model();
    tick_n      = 0;
    last_addr   = '0;
    p_hs        = !SYNC_POL;
    p_vs        = !SYNC_POL;
    p_rgb       = 3'b000;
    strobes     = 0;
    exp_strobes = 0;
  endtask

  task automatic hold_reset();
    reset_n = 1'b0;
    repeat (5) begin
      @(posedge clock); #1;
      check("rst_rd_en",   16'(bus.rd_en),   16'(0));
      check("rst_rd_addr", 16'(bus.rd_addr), 16'(0));
      check("rst_rgb",     16'(rgb),         16'(0));
      check("rst_fs",      16'(frame_start), 16'(0));
      check("rst_sync",    16'({hsync, vsync}), 16'({!SYNC_POL, !SYNC_POL}));
    end
    reset_n = 1'b1;
    restart_model();
  endtask

  task automatic run_ticks(input int count);
    for (int i = 0; i < count; i++) begin
      for (int c = 1; c < CLK_DIV; c++) begin
        @(posedge clock); #1;
        if (bus.rd_en) strobes++;
        check("gap_hold", 16'({bus.rd_en, frame_start, hsync, vsync, rgb}),
              16'({1'b0, 1'b0, p_hs, p_vs, p_rgb}));
        check("gap_addr", 16'(bus.rd_addr), 16'(last_addr));
      end
      @(posedge clock); #1;
      predict(tick_n);
      if (bus.rd_en) strobes++;
      check("hsync",       16'(hsync),       16'(e_hs));
      check("vsync",       16'(vsync),       16'(e_vs));
      check("rgb",         16'(rgb),         16'(e_rgb));
      check("frame_start", 16'(frame_start), 16'(e_fs));
      check("rd_en",       16'(bus.rd_en),   16'(e_re));
      check("rd_addr",     16'(bus.rd_addr), 16'(last_addr));
      p_hs  = e_hs;
      p_vs  = e_vs;
      p_rgb = e_rgb;
      tick_n++;
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem_img[i] = 16'($urandom);
    mem_img[0]  = 16'h0001;
    mem_img[1]  = 16'h0000;
    mem_img[31] = 16'h8000;
    mem_img[32] = 16'hFFFF;
    mem_img[63] = 16'h7FFE;
    tick_n = 0;

    // Power-up reset, then run into image row 3 and abort the frame mid-fetch.
    hold_reset();
    run_ticks(5000);
    check("strobe_count_a", 16'(strobes), 16'(exp_strobes));

    // Mid-frame reset: scan restarts at (0,0) and a whole frame plus the next frame start follow.
    hold_reset();
    run_ticks(V_TOT * H_TOT + 100);
    check("strobe_count_b", 16'(strobes), 16'(exp_strobes));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
